mux32_2to1: RTL and testbench

//   Registered 2:1 selector for 32-bit datapath words (e.g. adder-input select in
//   the CPU datapath). Chooses input1 or input2 by a 1-bit selector and presents
//   the result on a registered output one clock later. Output-valid flag and the

---
 rtl/mux32_2to1.sv | 54 +++++
 tb/tb_mux32_2to1.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mux32_2to1.sv
// Registered 2:1 word selector: picks input1 or input2 by selector and presents it
// one clock later, together with the select that produced it and a valid flag.
module mux32_2to1 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             selector,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] outputfinal,
  output logic             out_valid,
  output logic             sel_q
);

  logic [WIDTH-1:0] outputfinal_d, outputfinal_q;
  logic             out_valid_d, out_valid_q;
  logic             sel_d;

  // An unknown selector lands in the default branch, so sel_q never captures X.
  always_comb begin
    outputfinal_d = input1;
    sel_d         = 1'b0;
    out_valid_d   = 1'b1;
    case (selector)
      1'b1: begin
        outputfinal_d = input2;
        sel_d         = 1'b1;
      end
      default: begin
        outputfinal_d = input1;
        sel_d         = 1'b0;
      end
    endcase
  end

  // Stage boundary: selection registered; reset wins over any selection this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outputfinal_q <= RESET_VAL;
      out_valid_q   <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      outputfinal_q <= outputfinal_d;
      out_valid_q   <= out_valid_d;
      sel_q         <= sel_d;
    end
  end

  assign outputfinal = outputfinal_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_mux32_2to1.sv
// Self-checking bench for mux32_2to1: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the registered selector.
module tb_mux32_2to1;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             selector;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [WIDTH-1:0] outputfinal;
  logic             out_valid;
  logic             sel_q;

  int n_checks;
  int n_pass;

  // Behavioural model state: what the outputs must show after the last edge.
  logic [WIDTH-1:0] exp_out;
  logic             exp_vld;
  logic             exp_sel;

  mux32_2to1 #(
    .WIDTH    (WIDTH),
    .RESET_VAL('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .selector   (selector),
    .input1     (input1),
    .input2     (input2),
    .outputfinal(outputfinal),
    .out_valid  (out_valid),
    .sel_q      (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Model the edge from the inputs currently applied, clock it, then compare.
  task automatic tick(input string tag);
    if (!reset) begin
      exp_out = '0;
      exp_vld = 1'b0;
      exp_sel = 1'b0;
    end else begin
      exp_out = selector ? input2 : input1;
      exp_vld = 1'b1;
      exp_sel = selector;
    end
    @(posedge clk);
    #1;
    check({tag, "_out"}, outputfinal, exp_out);
    check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, exp_vld});
    check({tag, "_sel"}, {31'd0, sel_q}, {31'd0, exp_sel});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    selector = 1'b0;
    input1   = 32'd40;
    input2   = 32'd50;

    // 1: held in reset for five edges
    for (int i = 0; i < 5; i++) begin
      tick("rst_hold");
      check("rst_hold_const", outputfinal, 32'd0);
    end

    // 2: release with selector 0
    reset = 1'b1;
    tick("release");
    check("release_40", outputfinal, 32'd40);
    check("release_vld", {31'd0, out_valid}, 32'd1);

    // 3: selector toggles
    selector = 1'b1;
    tick("sel_to_1");
    check("sel_to_1_50", outputfinal, 32'd50);
    selector = 1'b0;
    tick("sel_to_0");
    check("sel_to_0_40", outputfinal, 32'd40);

    // 4: unselected input has no effect; selected input tracked with one cycle latency
    selector = 1'b1;
    tick("sel1_again");
    input1 = 32'hFFFF_FFFF;
    tick("unsel_change");
    check("unsel_stays_50", outputfinal, 32'd50);
    input2 = 32'h8000_0001;
    #2;
    check("no_comb_path", outputfinal, 32'd50);
    tick("sel_change");
    check("sel_tracks", outputfinal, 32'h8000_0001);

    // 5: reset reasserted mid-stream, then released
    reset = 1'b0;
    tick("reassert");
    check("reassert_zero", outputfinal, 32'd0);
    reset = 1'b1;
    tick("rerelease");
    check("rerelease_in2", outputfinal, 32'h8000_0001);
    check("rerelease_vld", {31'd0, out_valid}, 32'd1);

    // 6: selector toggling every cycle with random words
    for (int i = 0; i < 20; i++) begin
      selector = ~selector;
      input1   = $urandom;
      input2   = $urandom;
      tick("toggle");
    end

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 200; i++) begin
      selector = 1'($urandom_range(0, 1));
      input1   = $urandom;
      input2   = $urandom;
      reset    = ($urandom_range(0, 15) != 0);
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
